// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator command arbiter: FSM encoding,
// the 29-bit command layout and the default timing parameters.
package calc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int CMD_W    = 29;
  localparam int RW_BIT   = 28;
  localparam int ADDR_LSB = 20;
  localparam int ADDR_W   = 8;
  localparam int A_LSB    = 12;
  localparam int A_W      = 8;
  localparam int B_LSB    = 4;
  localparam int B_W      = 8;
  localparam int SEL_LSB  = 0;
  localparam int SEL_W    = 4;

  localparam int WR_HOLD_DEF    = 2;
  localparam int RD_TIMEOUT_DEF = 1023;

  // Field order mirrors the bit offsets above, MSB first.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [A_W-1:0]    a;
    logic [B_W-1:0]    b;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Per-requester command queue: power-of-two depth, head visible
// combinationally, push gated by full and pop gated by empty.
module cmd_fifo
  import calc_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = CMD_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_ready = (r_count != LP_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // storage array, no reset needed since count gates visibility
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Two-requester round-robin arbiter feeding a shared calculator: queues
// commands, issues write strobes and read handshakes, reports completion.
module calc_cmd_arbiter
  import calc_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_HOLD    = WR_HOLD_DEF,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [CMD_W-1:0] REQ0_CMD,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [CMD_W-1:0] REQ1_CMD,
  output logic             VALID_CMD,
  output logic             RW_MEM,
  output logic [7:0]       ADDR,
  output logic [7:0]       IN_A,
  output logic [7:0]       IN_B,
  output logic [3:0]       SEL,
  input  logic             BUSY,
  input  logic             CALC_ACTIVE,
  output logic             DONE0,
  output logic             DONE1,
  output logic             ABORT,
  output logic             TIMEOUT_ERR,
  output logic             GRANT
);

  localparam int CNT_MAX = (RD_TIMEOUT > WR_HOLD) ? RD_TIMEOUT : WR_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy_seen;
  logic             w_busy_seen_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  cmd_t             r_cmd;
  cmd_t             w_head;
  logic             w_load;
  logic             r_grant;
  logic             w_grant_nxt;
  logic             r_rr_next;
  logic             w_rr_next_nxt;
  logic             r_done0;
  logic             r_done1;
  logic             r_abort;
  logic             r_tout;
  logic             w_done0_nxt;
  logic             w_done1_nxt;
  logic             w_abort_nxt;
  logic             w_tout_nxt;
  logic             w_finish;
  logic             w_win;
  logic             w_pop0;
  logic             w_pop1;
  logic             w_empty0;
  logic             w_empty1;
  logic [CMD_W-1:0] w_data0;
  logic [CMD_W-1:0] w_data1;

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(CMD_W)) u_fifo0 (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (REQ0_VALID),
    .i_data  (REQ0_CMD),
    .o_ready (REQ0_READY),
    .i_pop   (w_pop0),
    .o_data  (w_data0),
    .o_empty (w_empty0)
  );

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(CMD_W)) u_fifo1 (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (REQ1_VALID),
    .i_data  (REQ1_CMD),
    .o_ready (REQ1_READY),
    .i_pop   (w_pop1),
    .o_data  (w_data1),
    .o_empty (w_empty1)
  );

  assign w_head      = w_win ? cmd_t'(w_data1) : cmd_t'(w_data0);
  assign VALID_CMD   = r_valid;
  assign RW_MEM      = r_cmd.rw;
  assign ADDR        = r_cmd.addr;
  assign IN_A        = r_cmd.a;
  assign IN_B        = r_cmd.b;
  assign SEL         = r_cmd.sel;
  assign GRANT       = r_grant;
  assign DONE0       = r_done0;
  assign DONE1       = r_done1;
  assign ABORT       = r_abort;
  assign TIMEOUT_ERR = r_tout;

  // next-state, strobe and pulse decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_busy_seen_nxt = r_busy_seen;
    w_valid_nxt     = 1'b0;
    w_load          = 1'b0;
    w_grant_nxt     = r_grant;
    w_rr_next_nxt   = r_rr_next;
    w_abort_nxt     = 1'b0;
    w_tout_nxt      = 1'b0;
    w_finish        = 1'b0;
    w_pop0          = 1'b0;
    w_pop1          = 1'b0;

    if (!w_empty0 && !w_empty1) begin
      w_win = r_rr_next;
    end else if (!w_empty1) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (CALC_ACTIVE && !BUSY && !(w_empty0 && w_empty1)) begin
          w_load          = 1'b1;
          w_pop0          = !w_win;
          w_pop1          = w_win;
          w_grant_nxt     = w_win;
          w_rr_next_nxt   = !w_win;
          w_cnt_nxt       = '0;
          w_busy_seen_nxt = 1'b0;
          w_state_nxt     = w_head.rw ? ST_WRITE : ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!CALC_ACTIVE) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == CNT_W'(WR_HOLD)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_READ: begin
        // r_cnt==0 is the launch cycle: the strobe is not out yet, so BUSY is ignored
        if (!CALC_ACTIVE) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == '0) begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_busy_seen && !BUSY) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == CNT_W'(RD_TIMEOUT)) begin
          w_tout_nxt  = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_valid_nxt     = 1'b1;
          w_cnt_nxt       = r_cnt + CNT_W'(1);
          w_busy_seen_nxt = r_busy_seen | BUSY;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_done0_nxt = w_finish && !r_grant;
    w_done1_nxt = w_finish && r_grant;
  end

  // state and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_busy_seen <= 1'b0;
      r_valid     <= 1'b0;
      r_cmd       <= '0;
      r_grant     <= 1'b0;
      r_rr_next   <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_abort     <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy_seen <= w_busy_seen_nxt;
      r_valid     <= w_valid_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_next   <= w_rr_next_nxt;
      r_done0     <= w_done0_nxt;
      r_done1     <= w_done1_nxt;
      r_abort     <= w_abort_nxt;
      r_tout      <= w_tout_nxt;
      if (w_load) begin
        r_cmd <= w_head;
      end else begin
        r_cmd <= r_cmd;
      end
    end
  end

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Self-checking bench for calc_cmd_arbiter: transaction-level reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_calc_cmd_arbiter;

  localparam int DEPTH = 4;
  localparam int WRH   = 2;
  localparam int RDT   = 1023;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ0_VALID, REQ1_VALID;
  logic        REQ0_READY, REQ1_READY;
  logic [28:0] REQ0_CMD, REQ1_CMD;
  logic        VALID_CMD, RW_MEM;
  logic [7:0]  ADDR, IN_A, IN_B;
  logic [3:0]  SEL;
  logic        BUSY, CALC_ACTIVE;
  logic        DONE0, DONE1, ABORT, TIMEOUT_ERR, GRANT;

  always #5 CLK = ~CLK;

  calc_cmd_arbiter #(.FIFO_DEPTH(DEPTH), .WR_HOLD(WRH), .RD_TIMEOUT(RDT)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_CMD(REQ0_CMD),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_CMD(REQ1_CMD),
    .VALID_CMD(VALID_CMD), .RW_MEM(RW_MEM), .ADDR(ADDR), .IN_A(IN_A), .IN_B(IN_B),
    .SEL(SEL), .BUSY(BUSY), .CALC_ACTIVE(CALC_ACTIVE),
    .DONE0(DONE0), .DONE1(DONE1), .ABORT(ABORT), .TIMEOUT_ERR(TIMEOUT_ERR), .GRANT(GRANT)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: queues, the command in flight and expected outputs
  logic [28:0] q0[$];
  logic [28:0] q1[$];
  logic [28:0] m_cmd;
  bit          m_active, m_launch, m_gap, m_seen, m_next, m_grant;
  int          m_left, m_vc;
  bit          e_valid, e_done0, e_done1, e_abort, e_tout;

  function automatic logic [36:0] exp_vec();
    return {q0.size() < DEPTH, q1.size() < DEPTH, e_valid, m_cmd,
            e_done0, e_done1, e_abort, e_tout, m_grant};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {REQ0_READY, REQ1_READY, VALID_CMD, RW_MEM, ADDR, IN_A, IN_B, SEL,
            DONE0, DONE1, ABORT, TIMEOUT_ERR, GRANT};
  endfunction

  task automatic end_cmd(input bit normal);
    e_valid  = 1'b0;
    m_active = 1'b0;
    m_gap    = 1'b1;
    if (normal) begin
      if (m_grant) e_done1 = 1'b1;
      else         e_done0 = 1'b1;
    end
  endtask

  // advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int sz0, sz1;
    bit who;
    e_done0 = 1'b0; e_done1 = 1'b0; e_abort = 1'b0; e_tout = 1'b0;
    if (RESET) begin
      q0.delete(); q1.delete();
      m_active = 1'b0; m_gap = 1'b0; m_next = 1'b0; m_grant = 1'b0;
      m_cmd = '0; e_valid = 1'b0;
      return;
    end
    sz0 = q0.size();
    sz1 = q1.size();
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_active) begin
      if (!CALC_ACTIVE) begin
        e_abort = 1'b1;
        end_cmd(1'b0);
      end else if (m_launch) begin
        m_launch = 1'b0;
        e_valid  = 1'b1;
        m_left   = WRH - 1;
        m_vc     = 1;
      end else if (m_cmd[28]) begin
        if (m_left == 0) end_cmd(1'b1);
        else m_left--;
      end else if (m_seen && !BUSY) begin
        end_cmd(1'b1);
      end else if (m_vc == RDT) begin
        e_tout = 1'b1;
        end_cmd(1'b0);
      end else begin
        m_vc++;
        if (BUSY) m_seen = 1'b1;
      end
    end else if (CALC_ACTIVE && !BUSY && (sz0 + sz1 > 0)) begin
      who      = (sz0 > 0 && sz1 > 0) ? m_next : (sz1 > 0);
      m_cmd    = who ? q1.pop_front() : q0.pop_front();
      m_grant  = who;
      m_next   = !who;
      m_active = 1'b1;
      m_launch = 1'b1;
      m_seen   = 1'b0;
    end
    if (REQ0_VALID && sz0 < DEPTH) q0.push_back(REQ0_CMD);
    if (REQ1_VALID && sz1 < DEPTH) q1.push_back(REQ1_CMD);
  endtask

  task automatic step();
    logic [36:0] d, e;
    model_step();
    @(negedge CLK);
    cyc++;
    d = dut_vec();
    e = exp_vec();
    total++;
    if (d !== e) begin
      bad++;
      $display("FAIL model_cmp cycle %0d: dut=%h expected=%h", cyc, d, e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic quiet();
    RESET = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    BUSY = 1'b0; CALC_ACTIVE = 1'b1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    int vc, dn, found, nd;
    logic [7:0] addrs [4];
    int c_dly, c_len, ca_off;
    bit c_started;

    REQ0_CMD = '0; REQ1_CMD = '0;
    quiet();
    CALC_ACTIVE = 1'b0;
    RESET = 1'b1;
    step(); step();
    chk("rst_valid", 32'(VALID_CMD), 32'd0);
    chk("rst_ready0", 32'(REQ0_READY), 32'd1);
    chk("rst_ready1", 32'(REQ1_READY), 32'd1);
    chk("rst_grant", 32'(GRANT), 32'd0);
    quiet();

    // single write on requester 0
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b1, 8'd0, 8'd10, 8'd7, 4'd0};
    step();
    REQ0_VALID = 1'b0;
    step();
    chk("wr_valid_t1", 32'(VALID_CMD), 32'd0);
    step();
    chk("wr_valid_t2", 32'(VALID_CMD), 32'd1);
    chk("wr_rw", 32'(RW_MEM), 32'd1);
    chk("wr_in_a", 32'(IN_A), 32'd10);
    chk("wr_in_b", 32'(IN_B), 32'd7);
    step();
    chk("wr_valid_t3", 32'(VALID_CMD), 32'd1);
    step();
    chk("wr_valid_t4", 32'(VALID_CMD), 32'd0);
    chk("wr_done0", 32'(DONE0), 32'd1);
    step();
    chk("wr_done0_once", 32'(DONE0), 32'd0);

    // contention right after reset: requester 0 first
    do_reset();
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b1, 8'd1, 8'd2, 8'd3, 4'd1};
    REQ1_VALID = 1'b1; REQ1_CMD = {1'b1, 8'd5, 8'd28, 8'd4, 4'd3};
    step();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    step();
    chk("cont_grant0", 32'(GRANT), 32'd0);
    repeat (3) step();
    chk("cont_done0", 32'(DONE0), 32'd1);
    repeat (2) step();
    chk("cont_grant1", 32'(GRANT), 32'd1);
    chk("cont_addr1", 32'(ADDR), 32'd5);
    chk("cont_a1", 32'(IN_A), 32'd28);
    chk("cont_b1", 32'(IN_B), 32'd4);
    chk("cont_sel1", 32'(SEL), 32'd3);
    repeat (3) step();
    chk("cont_done1", 32'(DONE1), 32'd1);
    step();

    // read handshake with BUSY high for 60 cycles
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b0, 8'd5, 8'd0, 8'd0, 4'd2};
    step();
    REQ0_VALID = 1'b0;
    step();
    vc = 0;
    step();
    if (VALID_CMD) vc++;
    BUSY = 1'b1;
    repeat (60) begin
      step();
      if (VALID_CMD) vc++;
    end
    BUSY = 1'b0;
    step();
    chk("rd_valid_cycles", 32'(vc), 32'd61);
    chk("rd_valid_drop", 32'(VALID_CMD), 32'd0);
    chk("rd_done0", 32'(DONE0), 32'd1);
    step(); step();

    // backpressure: five offers on requester 1 while BUSY holds the arbiter
    BUSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      REQ1_VALID = 1'b1;
      REQ1_CMD = {1'b1, 8'(i + 1), 8'd0, 8'd0, 4'd0};
      if (i == 4) chk("full_ready", 32'(REQ1_READY), 32'd0);
      step();
    end
    REQ1_VALID = 1'b0;
    BUSY = 1'b0;
    nd = 0;
    for (int k = 0; k < 80 && nd < 4; k++) begin
      step();
      if (DONE1) begin
        addrs[nd] = ADDR;
        nd++;
      end
    end
    chk("full_issued", 32'(nd), 32'd4);
    for (int i = 0; i < 4; i++) chk("full_order", 32'(addrs[i]), 32'(i + 1));
    step(); step();

    // read timeout with BUSY stuck low
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b0, 8'd9, 8'd1, 8'd1, 4'd0};
    step();
    REQ0_VALID = 1'b0;
    vc = 0; found = 0; dn = 0;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (DONE0) dn++;
      if (TIMEOUT_ERR) begin
        found = 1;
        break;
      end
      if (VALID_CMD) vc++;
    end
    chk("tout_seen", 32'(found), 32'd1);
    chk("tout_cycles", 32'(vc), 32'd1023);
    repeat (3) begin
      step();
      if (DONE0) dn++;
    end
    chk("tout_no_done", 32'(dn), 32'd0);

    // abort: CALC_ACTIVE drops mid-write
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b1, 8'd7, 8'd3, 8'd3, 4'd4};
    step();
    REQ0_VALID = 1'b0;
    step(); step();
    chk("abort_valid_pre", 32'(VALID_CMD), 32'd1);
    CALC_ACTIVE = 1'b0;
    step();
    chk("abort_pulse", 32'(ABORT), 32'd1);
    chk("abort_valid", 32'(VALID_CMD), 32'd0);
    CALC_ACTIVE = 1'b1;
    dn = 0;
    repeat (5) begin
      step();
      if (DONE0) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    // reset in the middle of a read with requester 1 queued
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b0, 8'd3, 8'd0, 8'd0, 4'd0};
    step();
    REQ0_VALID = 1'b0;
    step(); step();
    BUSY = 1'b1;
    REQ1_VALID = 1'b1; REQ1_CMD = {1'b1, 8'd8, 8'd0, 8'd0, 4'd0};
    step();
    REQ1_VALID = 1'b0;
    step();
    RESET = 1'b1;
    step();
    chk("rstmid_valid", 32'(VALID_CMD), 32'd0);
    chk("rstmid_ready1", 32'(REQ1_READY), 32'd1);
    chk("rstmid_pulses", 32'({DONE0, DONE1, ABORT, TIMEOUT_ERR}), 32'd0);
    quiet();
    repeat (3) step();
    chk("rstmid_empty", 32'(VALID_CMD), 32'd0);
    REQ0_VALID = 1'b1; REQ0_CMD = {1'b1, 8'd11, 8'd0, 8'd0, 4'd0};
    REQ1_VALID = 1'b1; REQ1_CMD = {1'b1, 8'd12, 8'd0, 8'd0, 4'd0};
    step();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    step();
    chk("rstmid_grant0", 32'(GRANT), 32'd0);
    repeat (20) step();

    // randomized traffic with a simple calculator responder
    c_started = 1'b0; c_dly = 0; c_len = 0; ca_off = 0;
    for (int n = 0; n < 4000; n++) begin
      RESET      = ($urandom_range(0, 499) == 0);
      REQ0_VALID = ($urandom_range(0, 2) == 0);
      REQ1_VALID = ($urandom_range(0, 2) == 0);
      REQ0_CMD   = 29'($urandom);
      REQ1_CMD   = 29'($urandom);
      if (ca_off > 0) begin
        ca_off--;
        CALC_ACTIVE = 1'b0;
      end else begin
        CALC_ACTIVE = 1'b1;
        if ($urandom_range(0, 199) == 0) ca_off = $urandom_range(1, 4);
      end
      if (e_valid && !m_cmd[28]) begin
        if (!c_started) begin
          c_started = 1'b1;
          c_dly = $urandom_range(0, 3);
          c_len = $urandom_range(1, 12);
        end
        if (c_dly > 0) begin
          c_dly--;
          BUSY = 1'b0;
        end else if (c_len > 0) begin
          c_len--;
          BUSY = 1'b1;
        end else begin
          BUSY = 1'b0;
        end
      end else begin
        c_started = 1'b0;
        BUSY = ($urandom_range(0, 9) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
